// File: rtl/bit_deserializer_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package bit_deserializer_pkg;

    typedef enum logic {IDLE, SHIFT} in_state_t;
    typedef enum logic {EMPTY, FULL} out_state_t;

    // One extra bit so the counter can hold WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_deserializer_if.sv
// Word output port of the deserializer: data/valid from the producer, ready from the consumer.
interface bit_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bit_deserializer_hold.sv
// One-word holding register between the non-stallable bit stream and the consumer.
//   state | meaning
//   EMPTY | no word held, valid low
//   FULL  | word held on data, valid high until the consumer takes it
module bit_deserializer_hold
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic [WIDTH-1:0]          i_word,
    bit_deserializer_if.master        out_if,
    output logic                      o_overflow
);

    out_state_t state_q, state_d;
    logic       drain;
    logic       take;
    logic       drop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= EMPTY;
            out_if.data <= '0;
            o_overflow  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) out_if.data <= i_word;
            if (drop) o_overflow  <= 1'b1;
        end
    end

    // A completing word may replace the held one only if that one leaves on this same edge.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        drop    = 1'b0;
        drain   = (state_q == FULL) && out_if.ready;
        if (i_load) begin
            if ((state_q == EMPTY) || drain) begin
                take    = 1'b1;
                state_d = FULL;
            end else begin
                drop = 1'b1;
            end
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        out_if.valid = (state_q == FULL);
    end

endmodule

// File: rtl/bit_deserializer.sv
// Collects qualified serial bits into WIDTH-bit words and hands them to a one-word holding register.
//   state | meaning
//   IDLE  | bit count is zero, next valid bit starts a word
//   SHIFT | partial word in progress, count in 1..WIDTH-1
module bit_deserializer
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_d,
    input  logic               i_d_valid,
    input  logic               i_sof,
    bit_deserializer_if.master out_if,
    output logic               o_overflow,
    output logic               o_busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int IW = $clog2(WIDTH);

    in_state_t        state_q, state_d;
    logic [CW-1:0]    count_q, count_d, count_inc;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    pos, idx;
    logic             word_done;
    logic             busy_d;
    logic             load;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
            o_busy  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            o_busy  <= busy_d;
        end
    end

    // A start-of-frame mid-word restarts assembly at position 0, discarding the partial bits.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        pos       = '0;
        idx       = '0;
        count_inc = '0;
        if (i_d_valid) begin
            if ((state_q == SHIFT) && !i_sof) pos = count_q[IW-1:0];
            else                              shreg_d = '0;
            idx = MSB_FIRST ? (IW'(WIDTH - 1) - pos) : pos;
            shreg_d[idx] = i_d;
            count_inc = CW'(pos) + CW'(1);
            if (count_inc == CW'(WIDTH)) begin
                word_done = 1'b1;
                count_d   = '0;
                state_d   = IDLE;
            end else begin
                count_d = count_inc;
                state_d = SHIFT;
            end
        end
    end

    always_comb begin
        load   = word_done;
        busy_d = (count_d != '0);
    end

    // shreg_d already carries the final bit, so the word reaches the holding register on the completing edge.
    bit_deserializer_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (load),
        .i_word     (shreg_d),
        .out_if     (out_if),
        .o_overflow (o_overflow)
    );

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer: LSB-first and MSB-first instances share stimulus, scoreboard checks words.
module tb_bit_deserializer;

    logic clk = 1'b0;
    logic rst, d, d_valid, sof, ready;
    logic ovf0, busy0, ovf1, busy1;

    bit_deserializer_if #(.WIDTH(8)) if0 ();
    bit_deserializer_if #(.WIDTH(8)) if1 ();
    assign if0.ready = ready;
    assign if1.ready = ready;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_d(d), .i_d_valid(d_valid), .i_sof(sof),
        .out_if(if0), .o_overflow(ovf0), .o_busy(busy0));

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_d(d), .i_d_valid(d_valid), .i_sof(sof),
        .out_if(if1), .o_overflow(ovf1), .o_busy(busy1));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_words = 0;
    int n_valid_cycles = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last0, last1;

    // Reference model state
    int         m_cnt  = 0;
    logic [7:0] m_word = 8'h00;
    logic       m_full = 1'b0;
    logic       m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic cycle(input logic bit_d, input logic bit_v, input logic bit_sof);
        logic done;
        logic [7:0] e;
        d = bit_d; d_valid = bit_v; sof = bit_sof;
        if (if0.valid === 1'b1) n_valid_cycles++;
        if ((if0.valid === 1'b1) && ready) begin
            chk("word0_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("word0_data", 64'(if0.data), 64'(e));
                last0 = if0.data;
                n_words++;
            end
        end
        if ((if1.valid === 1'b1) && ready) begin
            chk("word1_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("word1_data", 64'(if1.data), 64'(e));
                last1 = if1.data;
            end
        end
        done = 1'b0;
        if (bit_v) begin
            if ((m_cnt == 0) || bit_sof) begin
                m_word = 8'h00;
                m_cnt  = 0;
            end
            m_word[m_cnt] = bit_d;
            m_cnt++;
            if (m_cnt == 8) begin
                done  = 1'b1;
                m_cnt = 0;
            end
        end
        if (done) begin
            if (!m_full || ready) begin
                q0.push_back(m_word);
                q1.push_back(rev8(m_word));
                m_full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_full && ready) begin
            m_full = 1'b0;
        end
        @(posedge clk); #1;
        chk("busy0",  64'(busy0),     64'(m_cnt != 0));
        chk("busy1",  64'(busy1),     64'(m_cnt != 0));
        chk("valid0", 64'(if0.valid), 64'(m_full));
        chk("valid1", 64'(if1.valid), 64'(m_full));
        chk("ovf0",   64'(ovf0),      64'(m_ovf));
        chk("ovf1",   64'(ovf1),      64'(m_ovf));
    endtask

    task automatic send_word(input logic [7:0] w, input logic first_sof, input logic last_ready);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ready = last_ready;
            cycle(w[i], 1'b1, (i == 0) ? first_sof : 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; d_valid = 1'b0; sof = 1'b0; d = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0; m_full = 1'b0; m_ovf = 1'b0; m_word = 8'h00;
        q0.delete(); q1.delete();
        chk("rst_valid", 64'(if0.valid), 64'd0);
        chk("rst_busy",  64'(busy0),     64'd0);
        chk("rst_ovf",   64'(ovf0),      64'd0);
        chk("rst_data0", 64'(if0.data),  64'd0);
        chk("rst_data1", 64'(if1.data),  64'd0);
    endtask

    initial begin
        int w0;
        int vc0;
        rst = 1'b1; d = 1'b0; d_valid = 1'b0; sof = 1'b0; ready = 1'b1;
        last0 = 8'h00; last1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Back-to-back bits, consumer always ready
        vc0 = n_valid_cycles; w0 = n_words;
        send_word(8'h4D, 1'b0, 1'b1);
        chk("t1_valid_now", 64'(if0.valid), 64'd1);
        chk("t1_data_now",  64'(if0.data),  64'h4D);
        idle(3);
        chk("t1_valid_cycles", 64'(n_valid_cycles - vc0), 64'd1);
        chk("t1_words", 64'(n_words - w0), 64'd1);
        chk("t1_lsb", 64'(last0), 64'h4D);
        chk("t1_msb", 64'(last1), 64'hB2);
        chk("t1_ovf", 64'(ovf0), 64'd0);

        // Gapped input
        w0 = n_words;
        for (int i = 0; i < 8; i++) begin
            cycle(((8'h4D >> i) & 8'h01) != 0, 1'b1, 1'b0);
            if (i != 7) chk("t2_busy_gap_pre", 64'(busy0), 64'd1);
            cycle(1'b0, 1'b0, 1'b0);
        end
        idle(2);
        chk("t2_words", 64'(n_words - w0), 64'd1);
        chk("t2_lsb", 64'(last0), 64'h4D);

        // Backpressure: second word dropped
        ready = 1'b0;
        send_word(8'h4D, 1'b0, 1'b0);
        send_word(8'h11, 1'b0, 1'b0);
        idle(2);
        chk("t3_data_held", 64'(if0.data),  64'h4D);
        chk("t3_valid",     64'(if0.valid), 64'd1);
        chk("t3_ovf",       64'(ovf0),      64'd1);
        ready = 1'b1;
        idle(1);
        chk("t3_valid_fall", 64'(if0.valid), 64'd0);
        chk("t3_last",       64'(last0),     64'h4D);
        idle(1);

        // Drain and completion on the same edge
        do_reset();
        ready = 1'b0;
        send_word(8'h4D, 1'b0, 1'b0);
        idle(2);
        send_word(8'hA5, 1'b0, 1'b1);
        chk("t4_valid",  64'(if0.valid), 64'd1);
        chk("t4_data",   64'(if0.data),  64'hA5);
        chk("t4_data1",  64'(if1.data),  64'(rev8(8'hA5)));
        chk("t4_ovf",    64'(ovf0),      64'd0);
        chk("t4_popped", 64'(last0),     64'h4D);
        idle(2);
        chk("t4_last", 64'(last0), 64'hA5);

        // Mid-frame start of frame
        w0 = n_words;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        send_word(8'h3C, 1'b1, 1'b1);
        idle(3);
        chk("t5_words", 64'(n_words - w0), 64'd1);
        chk("t5_lsb", 64'(last0), 64'h3C);
        chk("t5_msb", 64'(last1), 64'h3C);

        // Reset with a partial word in flight
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("t6_busy_pre", 64'(busy0), 64'd1);
        do_reset();
        w0 = n_words;
        send_word(8'h5A, 1'b0, 1'b1);
        idle(3);
        chk("t6_words", 64'(n_words - w0), 64'd1);
        chk("t6_lsb", 64'(last0), 64'h5A);
        chk("t6_msb", 64'(last1), 64'h5A);

        chk("sb0_empty", 64'(q0.size()), 64'd0);
        chk("sb1_empty", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
Serial-to-parallel stage directly downstream of the single-bit registered data stage. Collects qualified serial bits into WIDTH-bit words and presents them on a valid/ready output port. A one-word holding register decouples the non-stallable bit stream from consumer backpressure. Words that cannot be stored are dropped and flagged.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
MSB_FIRST, 0, 0 = first received bit lands in o_data[0]; 1 = first received bit lands in o_data[WIDTH-1].

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst  input  1  reset; synchronous, active-high.
i_d  input  1  serial data bit from the upstream register stage.
i_d_valid  input  1  i_d is a valid bit this cycle.
i_sof  input  1  start of frame; qualified by i_d_valid.
o_data  output  WIDTH  assembled word.
o_valid  output  1  o_data holds a word.
i_ready  input  1  consumer accepts the word when o_valid & i_ready.
o_overflow  output  1  sticky; a completed word was dropped.
o_busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset (i_rst=1 at a clock edge): bit count=0, shift register=0, o_valid=0, o_data=0, o_overflow=0, o_busy=0. A partial word or held word is discarded. Reset has priority over every other event in that cycle.
- Input state machine:
  - IDLE (count=0): on i_d_valid, store the bit at position 0 and go to SHIFT with count=1. i_sof is irrelevant in IDLE.
  - SHIFT (1..WIDTH-1): on i_d_valid & !i_sof, store the bit at position count and increment count.
  - SHIFT, i_d_valid & i_sof: discard the partial word, store the bit at position 0, set count=1. No error flag.
  - Count reaching WIDTH completes the word. Count returns to 0 (IDLE) in the same edge.
  - No i_d_valid: hold state.
- Bit placement: LSB-first positions map to o_data index = position. For MSB_FIRST=1, index = WIDTH-1-position.
- Output holding register: EMPTY/FULL, o_valid = FULL.
  - Latency: the word appears with o_valid=1 on the cycle after the edge that captured its last bit. Equivalently, the completion edge loads the holding register directly.
  - On completion, the word loads if the register is EMPTY, or if it is FULL and being drained the same cycle (o_valid & i_ready). In that case o_valid stays 1 with the new data and there is no bubble.
  - On completion while FULL and i_ready=0: the new word is dropped, the held word is kept unchanged, and o_overflow is set to 1.
  - o_data is stable while o_valid & !i_ready. It is not cleared on drain; its value is don't-care when o_valid=0.
  - Drain without completion: FULL goes to EMPTY.
- o_overflow clears only on reset.
- o_busy = (count != 0), registered.
- Count register width: clog2(WIDTH)+1 bits, wide enough to hold WIDTH without wrap.

Decomposition:
- Shared package bit_deserializer_pkg holds:
  - typedef in_state_t {IDLE, SHIFT}
  - typedef out_state_t {EMPTY, FULL}
  - function for the count width from WIDTH
- One sub-module, bit_deserializer_hold: the WIDTH-bit holding register with valid/ready, load strobe and drop/overflow logic. The top level keeps the shift register and counter.

Test Plan:
- WIDTH=8, MSB_FIRST=0, i_ready=1: bits 1,0,1,1,0,0,1,0 on consecutive cycles -> o_valid=1 for exactly one cycle, one cycle after the 8th bit, with o_data=0x4D; o_overflow=0.
- Same bit sequence with MSB_FIRST=1 -> o_data=0xB2.
- Gapped input: i_d_valid toggling 1,0,1,0..., 8 bits total -> identical word 0x4D; o_busy=1 from the first bit until the completion edge.
- Backpressure, i_ready=0: send 0x4D then 0x11. -> o_data stays 0x4D, o_valid=1, o_overflow=1 after the second word completes. Raise i_ready -> o_valid falls the next cycle.
- Simultaneous drain and completion: word A=0x4D held; assert i_ready on the same cycle word B=0xA5 completes -> o_valid stays 1, o_data=0xA5 next cycle, o_overflow=0.
- Mid-frame i_sof after 3 bits, then 8 fresh bits for 0x3C -> a single word 0x3C. Separately, i_rst after 5 bits -> o_busy=0 and o_valid=0; the next 8 bits give one correct word.
